spi_cmd_sequencer: RTL

//  Command front-end between the SPI slave byte receiver and the convolution engine in archlearn.

---
 rtl/spi_cmd_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// spi_cmd_sequencer : SPI 2-byte command parser driving engine memory and runs
// Revision: 1.0
// ============================================================================
module spi_cmd_sequencer #(
   parameter int ADDR_W  = 13,
   parameter int LEN_W   = 9,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   output logic              eng_start,
   output logic [LEN_W-1:0]  eng_len,
   input  logic              eng_done,
   output logic              convout,
   output logic [7:0]        status
);

   localparam int TM_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [0:0] P_OP  = 1'b0;
   localparam logic [0:0] P_ARG = 1'b1;

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_ISSUE = 2'd1;
   localparam logic [1:0] R_BUSY  = 2'd2;
   localparam logic [1:0] R_DONE  = 2'd3;

   localparam logic [7:0] OP_CLEAR  = 8'h01;
   localparam logic [7:0] OP_SETLEN = 8'h10;
   localparam logic [7:0] OP_LOAD   = 8'h24;
   localparam logic [7:0] OP_START  = 8'h31;

   logic [0:0]        p_q, p_d;
   logic [7:0]        op_q, op_d;
   logic [TM_W-1:0]   tcnt_q, tcnt_d;
   logic [1:0]        run_q, run_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              err_q, err_d, ovf_q, ovf_d, tmo_q, tmo_d, conv_q, conv_d;
   logic              we_q, we_d, start_q, start_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              busy;

   assign busy = (run_q == R_ISSUE) || (run_q == R_BUSY);

   always_comb begin
      p_d     = p_q;
      op_d    = op_q;
      tcnt_d  = tcnt_q;
      run_d   = run_q;
      ptr_d   = ptr_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      tmo_d   = tmo_q;
      conv_d  = conv_q;
      we_d    = 1'b0;
      start_d = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      len_d   = len_q;

      case (run_q)
         R_ISSUE: run_d = R_BUSY;
         R_BUSY: begin
            if (eng_done) begin
               run_d  = R_DONE;
               conv_d = 1'b1;
            end
         end
         default: ;
      endcase

      // Opcode decode runs after the run FSM so CLEAR overrides a same-cycle done for convout.
      case (p_q)
         P_OP: begin
            if (rx_valid) begin
               op_d   = rx_data;
               p_d    = P_ARG;
               tcnt_d = '0;
            end
         end
         default: begin
            if (rx_valid) begin
               p_d = P_OP;
               case (op_q)
                  OP_LOAD: begin
                     if (busy) begin
                        err_d = 1'b1;
                     end else begin
                        we_d    = 1'b1;
                        waddr_d = ptr_q;
                        wdata_d = rx_data;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        if (&ptr_q) ovf_d = 1'b1;
                     end
                  end
                  OP_SETLEN: begin
                     if (busy) err_d = 1'b1;
                     else      len_d = LEN_W'(rx_data) + LEN_W'(1);
                  end
                  OP_START: begin
                     if ((run_q == R_IDLE) || (run_q == R_DONE)) begin
                        conv_d  = 1'b0;
                        run_d   = R_ISSUE;
                        start_d = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_CLEAR: begin
                     ptr_d  = '0;
                     err_d  = 1'b0;
                     ovf_d  = 1'b0;
                     tmo_d  = 1'b0;
                     conv_d = 1'b0;
                  end
                  default: err_d = 1'b1;
               endcase
            end else if (tcnt_q == TM_W'(TIMEOUT - 1)) begin
               p_d   = P_OP;
               tmo_d = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TM_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_q     <= P_OP;
         op_q    <= '0;
         tcnt_q  <= '0;
         run_q   <= R_IDLE;
         ptr_q   <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         conv_q  <= 1'b0;
         we_q    <= 1'b0;
         start_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         len_q   <= LEN_W'(256);
      end else begin
         p_q     <= p_d;
         op_q    <= op_d;
         tcnt_q  <= tcnt_d;
         run_q   <= run_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
         conv_q  <= conv_d;
         we_q    <= we_d;
         start_q <= start_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         len_q   <= len_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;
   assign eng_start = start_q;
   assign eng_len   = len_q;
   assign convout   = conv_q;
   assign status    = {busy, conv_q, err_q, ovf_q, tmo_q, 3'b000};

endmodule
`default_nettype wire
